// File: rtl/usb_fs_tx_gen.sv
// rtl/usb_fs_tx_gen.sv - single-clock USB full-speed packet transmitter; define USB_TX_TOKEN_EN for token/CRC5 packets
module usb_fs_tx_gen #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_PAYLOAD  = 64,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pkt_start,
    input  logic [3:0]                         pid,
`ifdef USB_TX_TOKEN_EN
    input  logic [10:0]                        token_field,
`endif
    output logic                               busy,
    output logic                               pkt_end,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [7:0]                         tx_data,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   byte_count,
    output logic                               overflow,
    output logic                               oe,
    output logic                               dp,
    output logic                               dn
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_HI, S_CRC_LO, S_TOKEN0, S_TOKEN1, S_EOP
    } state_t;

`ifdef USB_TX_TOKEN_EN
    localparam bit TOKEN_EN = 1'b1;
    logic [10:0] token_in;
    assign token_in = token_field;
`else
    localparam bit TOKEN_EN = 1'b0;
    logic [10:0] token_in;
    assign token_in = 11'd0;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [15:0]   sh;
    logic [4:0]    nbits;
    logic [2:0]    run;
    logic [15:0]   crc16;
    logic [4:0]    crc5;
    logic [3:0]    pid_r;
    logic [10:0]   token_r;

    logic          accept, tick, stuffing, field_done, advance;
    logic          data_path, token_path, slot, take, ovf;
    logic          load_en, eop_enter, emit, bit_val, crc16_en, crc5_en;
    logic [15:0]   load_val;
    logic [4:0]    load_len;
    logic [7:0]    crc_hi_f, crc_lo_f;
    logic [4:0]    crc5_f;

    // A start is also taken in the pkt_end cycle so packets can run back to back.
    assign accept     = pkt_start && (!busy || pkt_end);
    assign tick       = (state != S_IDLE) && (cnt == CW'(CLKS_PER_BIT - 1));
    assign stuffing   = tick && (state != S_EOP) && (run == 3'd6);
    assign field_done = (nbits == 5'd0);
    assign advance    = tick && !stuffing && field_done;
    assign data_path  = (pid_r[1:0] == 2'b11);
    assign token_path = TOKEN_EN && (pid_r[1:0] == 2'b01);
    assign slot       = advance && ((state == S_DATA) || ((state == S_PID) && data_path));
    assign take       = slot && tx_valid && (byte_count != BCW'(MAX_PAYLOAD));
    assign ovf        = slot && tx_valid && (byte_count == BCW'(MAX_PAYLOAD));

    always_comb begin
        crc_hi_f = '0;
        crc_lo_f = '0;
        crc5_f   = '0;
        for (int i = 0; i < 8; i++) begin
            crc_hi_f[i] = ~crc16[15-i];
            crc_lo_f[i] = ~crc16[7-i];
        end
        for (int i = 0; i < 5; i++) begin
            crc5_f[i] = ~crc5[4-i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (accept) begin
            state_n = S_SYNC;
        end else if (advance) begin
            case (state)
                S_SYNC:   state_n = S_PID;
                S_PID:    state_n = data_path ? (take ? S_DATA : S_CRC_HI)
                                              : (token_path ? S_TOKEN0 : S_EOP);
                S_DATA:   state_n = take ? S_DATA : S_CRC_HI;
                S_CRC_HI: state_n = S_CRC_LO;
                S_CRC_LO: state_n = S_EOP;
                S_TOKEN0: state_n = S_TOKEN1;
                S_TOKEN1: state_n = S_EOP;
                S_EOP:    state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // At a field boundary the next field is loaded and its first bit goes out on the same tick.
    always_comb begin
        load_en   = 1'b0;
        load_val  = '0;
        load_len  = '0;
        eop_enter = 1'b0;
        if (advance) begin
            case (state)
                S_SYNC: begin
                    load_en  = 1'b1;
                    load_val = {8'd0, ~pid_r, pid_r};
                    load_len = 5'd8;
                end
                S_PID, S_DATA: begin
                    if (slot) begin
                        load_en  = 1'b1;
                        load_val = take ? {8'd0, tx_data} : {8'd0, crc_hi_f};
                        load_len = 5'd8;
                    end else if (token_path) begin
                        load_en  = 1'b1;
                        load_val = {5'd0, token_r};
                        load_len = 5'd11;
                    end else begin
                        eop_enter = 1'b1;
                    end
                end
                S_CRC_HI: begin
                    load_en  = 1'b1;
                    load_val = {8'd0, crc_lo_f};
                    load_len = 5'd8;
                end
                S_TOKEN0: begin
                    load_en  = 1'b1;
                    load_val = {11'd0, crc5_f};
                    load_len = 5'd5;
                end
                S_CRC_LO, S_TOKEN1: eop_enter = 1'b1;
                default: ;
            endcase
        end
        bit_val  = stuffing ? 1'b0 : (field_done ? load_val[0] : sh[0]);
        emit     = stuffing || (tick && (state != S_EOP) && (!field_done || load_en));
        crc16_en = tick && !stuffing && (((state == S_DATA) && !field_done) || take);
        crc5_en  = tick && !stuffing && (((state == S_TOKEN0) && !field_done) ||
                                         ((state == S_PID) && advance && token_path));
        tx_ready = slot && !ovf;
        overflow = ovf;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            sh         <= '0;
            nbits      <= '0;
            run        <= '0;
            crc16      <= 16'hFFFF;
            crc5       <= 5'h1F;
            pid_r      <= '0;
            token_r    <= '0;
            byte_count <= '0;
            oe         <= 1'b0;
            dp         <= 1'b1;
            dn         <= 1'b0;
            busy       <= 1'b0;
            pkt_end    <= 1'b0;
        end else begin
            pkt_end <= 1'b0;
            if (accept) begin
                // First SYNC bit is a 0, so the idle J turns into K right away.
                cnt        <= '0;
                sh         <= 16'h0040;
                nbits      <= 5'd7;
                run        <= '0;
                crc16      <= 16'hFFFF;
                crc5       <= 5'h1F;
                pid_r      <= pid;
                token_r    <= token_in;
                byte_count <= '0;
                oe         <= 1'b1;
                dp         <= 1'b0;
                dn         <= 1'b1;
                busy       <= 1'b1;
            end else begin
                if (pkt_end) busy <= 1'b0;
                if (state != S_IDLE) cnt <= tick ? '0 : cnt + 1'b1;
                if (emit) begin
                    run <= bit_val ? run + 3'd1 : 3'd0;
                    if (!bit_val) begin
                        dp <= ~dp;
                        dn <= ~dn;
                    end
                end
                if (load_en) begin
                    sh    <= load_val >> 1;
                    nbits <= load_len - 5'd1;
                end else if (tick && !stuffing && !field_done && (state != S_EOP)) begin
                    sh    <= sh >> 1;
                    nbits <= nbits - 5'd1;
                end
                if (crc16_en) crc16 <= {crc16[14:0], 1'b0} ^ ((bit_val ^ crc16[15]) ? 16'h8005 : 16'h0000);
                if (crc5_en)  crc5  <= {crc5[3:0], 1'b0} ^ ((bit_val ^ crc5[4]) ? 5'h05 : 5'h00);
                if (take) byte_count <= byte_count + 1'b1;
                if (eop_enter) begin
                    dp    <= 1'b0;
                    dn    <= 1'b0;
                    nbits <= 5'(EOP_SE0_BITS);
                end
                if (tick && (state == S_EOP)) begin
                    if (nbits > 5'd1) begin
                        nbits <= nbits - 5'd1;
                    end else if (nbits == 5'd1) begin
                        nbits <= 5'd0;
                        dp    <= 1'b1;
                        dn    <= 1'b0;
                    end else begin
                        oe      <= 1'b0;
                        pkt_end <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_fs_tx_gen.sv
// tb/tb_usb_fs_tx_gen.sv - randomized bench for usb_fs_tx_gen against a packet-level line model
module tb_usb_fs_tx_gen;
    localparam int CPB  = 4;
    localparam int MAXP = 4;
    localparam int SE0  = 2;

    logic clk = 1'b0;
    logic reset_n, pkt_start, tx_valid;
    logic [3:0] pid;
    logic [7:0] tx_data;
    logic busy, pkt_end, tx_ready, overflow, oe, dp, dn;
    logic [$clog2(MAXP+1)-1:0] byte_count;
`ifdef USB_TX_TOKEN_EN
    logic [10:0] token_field;
`endif

    int checks = 0;
    int failures = 0;
    int last_oe_cycles;
    int last_bc;
    logic [7:0]  pay [8];
    logic [10:0] tok;
    bit          nrz_q [$];
    logic [1:0]  exp_lv [$];

    always #5 clk = ~clk;

    usb_fs_tx_gen #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP), .EOP_SE0_BITS(SE0)) dut (
        .clk(clk), .reset_n(reset_n), .pkt_start(pkt_start), .pid(pid),
`ifdef USB_TX_TOKEN_EN
        .token_field(token_field),
`endif
        .busy(busy), .pkt_end(pkt_end), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .byte_count(byte_count), .overflow(overflow),
        .oe(oe), .dp(dp), .dn(dn)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_lsb(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) nrz_q.push_back(v[i]);
    endtask

    // Expected {dp,dn} for every bit time of one packet: fields -> stuffing -> NRZI -> EOP.
    task automatic build_expected(input logic [3:0] p, input int n_acc);
        logic [15:0] c;
        int run;
        logic [1:0] lvl;
        nrz_q.delete();
        exp_lv.delete();
        push_lsb(16'h0080, 8);
        push_lsb({8'd0, ~p, p}, 8);
        if (p[1:0] == 2'b11) begin
            c = 16'hFFFF;
            for (int k = 0; k < n_acc; k++) begin
                push_lsb({8'd0, pay[k]}, 8);
                for (int i = 0; i < 8; i++)
                    c = (pay[k][i] ^ c[15]) ? ((c << 1) ^ 16'h8005) : (c << 1);
            end
            for (int i = 15; i >= 0; i--) nrz_q.push_back(~c[i]);
        end
`ifdef USB_TX_TOKEN_EN
        else if (p[1:0] == 2'b01) begin
            logic [4:0] c5;
            c5 = 5'h1F;
            push_lsb({5'd0, tok}, 11);
            for (int i = 0; i < 11; i++)
                c5 = (tok[i] ^ c5[4]) ? ((c5 << 1) ^ 5'h05) : (c5 << 1);
            for (int i = 4; i >= 0; i--) nrz_q.push_back(~c5[i]);
        end
`endif
        run = 0;
        lvl = 2'b10;
        foreach (nrz_q[i]) begin
            if (nrz_q[i] == 1'b0) lvl = ~lvl;
            run = nrz_q[i] ? run + 1 : 0;
            exp_lv.push_back(lvl);
            if (run == 6) begin
                lvl = ~lvl;
                run = 0;
                exp_lv.push_back(lvl);
            end
        end
        for (int i = 0; i < SE0; i++) exp_lv.push_back(2'b00);
        exp_lv.push_back(2'b10);
    endtask

    // Starts a packet now; returns at the negedge of the pkt_end cycle.
    task automatic run_pkt(input logic [3:0] p, input int n_offer, input int poke_at);
        int acc_exp, ovf_exp, hs, ovf, ends, idx, cyc;
        bit done;
        logic [1:0] obs [$];
        logic [7:0] w;
        acc_exp = (p[1:0] == 2'b11) ? ((n_offer < MAXP) ? n_offer : MAXP) : 0;
        ovf_exp = ((p[1:0] == 2'b11) && (n_offer > MAXP)) ? 1 : 0;
        hs = 0; ovf = 0; ends = 0; idx = 0; cyc = 0; done = 1'b0;
        build_expected(p, acc_exp);
        pid       = p;
        pkt_start = 1'b1;
        tx_valid  = (n_offer > 0);
        tx_data   = pay[0];
        @(posedge clk); #1;
        pkt_start = 1'b0;
        pid       = 4'($urandom);
        check("busy_after_start", busy, 1);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (pkt_end) ends++;
            if (overflow) ovf++;
            if (!oe) begin
                done = 1'b1;
            end else begin
                obs.push_back({dp, dn});
                if (tx_ready && tx_valid) begin
                    hs++;
                    idx++;
                end
                @(posedge clk); #1;
                pkt_start = (cyc == poke_at);
                tx_valid  = (idx < n_offer);
                tx_data   = pay[idx % 8];
            end
        end
        tx_valid = 1'b0;
        check("oe_fall_seen", done, 1);
        check("pkt_end_at_oe_fall", pkt_end, 1);
        check("busy_in_end_cycle", busy, 1);
        check("pkt_end_pulses", ends, 1);
        check("oe_cycles", obs.size(), CPB * exp_lv.size());
        foreach (exp_lv[i]) begin
            for (int k = 0; k < 4; k++)
                w[7-2*k -: 2] = (4*i + k < obs.size()) ? obs[4*i + k] : 2'bxx;
            checks++;
            if (w !== {4{exp_lv[i]}}) begin
                failures++;
                $display("FAIL line_bit%0d: got %0h expected %0h", i, w, {4{exp_lv[i]}});
                break;
            end
        end
        check("byte_count", byte_count, acc_exp);
        check("bytes_handshaken", hs, acc_exp);
        check("overflow_pulses", ovf, ovf_exp);
        last_oe_cycles = obs.size();
        last_bc = acc_exp;
    endtask

    task automatic fill_payload();
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    endtask

    initial begin
        int gap, cyc, seen;
        reset_n = 1'b0; pkt_start = 1'b0; tx_valid = 1'b0; pid = 4'h0; tx_data = 8'h00;
        tok = 11'd0;
`ifdef USB_TX_TOKEN_EN
        token_field = 11'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", oe, 0);
        check("rst_dp", dp, 1);
        check("rst_dn", dn, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_pkt_end", pkt_end, 0);
        check("rst_overflow", overflow, 0);
        check("rst_byte_count", byte_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        fill_payload();
        run_pkt(4'h2, 0, 0);
        check("ack_oe_76", last_oe_cycles, 76);
        @(negedge clk);
        run_pkt(4'h3, 0, 0);
        @(negedge clk);
        fill_payload();
        pay[0] = 8'hFF;
        run_pkt(4'hB, 1, 0);
        @(negedge clk);
        fill_payload();
        run_pkt(4'h3, 6, 0);
        @(negedge clk);

        for (int n = 0; n < 25; n++) begin
            fill_payload();
`ifdef USB_TX_TOKEN_EN
            tok = 11'($urandom);
            token_field = tok;
`endif
            run_pkt(4'($urandom), $urandom_range(0, 6), ($urandom_range(0, 1) == 1) ? $urandom_range(5, 50) : 0);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                @(negedge clk);
                check("busy_idle", busy, 0);
                check("byte_count_hold", byte_count, last_bc);
                repeat (gap - 1) @(negedge clk);
            end
        end

`ifdef USB_TX_TOKEN_EN
        tok = 11'd0;
        token_field = 11'd0;
        run_pkt(4'hD, 0, 10);
        @(negedge clk);
`endif

        pid = 4'hB; pkt_start = 1'b1; tx_valid = 1'b1; tx_data = 8'($urandom);
        @(posedge clk); #1;
        pkt_start = 1'b0;
        cyc = 0;
        while (byte_count != 2 && cyc < 2000) begin
            @(posedge clk); #1;
            tx_data = 8'($urandom);
            cyc++;
        end
        check("reached_byte2", byte_count, 2);
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_oe", oe, 0);
        check("midrst_dp", dp, 1);
        check("midrst_dn", dn, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pkt_end", pkt_end, 0);
        check("midrst_byte_count", byte_count, 0);
        reset_n = 1'b1;
        tx_valid = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (pkt_end || oe) seen++;
        end
        check("quiet_after_reset", seen, 0);
        fill_payload();
        run_pkt(4'hB, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
